// File: rtl/mem_bridge_pkg.sv
// Shared FSM state type and byte-lane helpers for mem_bridge.
package mem_bridge_pkg;

   typedef enum logic [1:0] {StIdle, StRd, StWr, StWdone} state_e;

   function automatic logic [3:0] lane_be(input logic [1:0] lane);
      return 4'b0001 << lane;
   endfunction

   function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] lane);
      return word[{lane, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/mem_bridge_wbuf.sv
// One-entry posted write buffer; used by mem_bridge only when MEM_BRIDGE_WBUF_EN is defined.
module mem_bridge_wbuf
   import mem_bridge_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        push_i,
   input  logic        pop_i,
   input  logic [29:0] addr_i,
   input  logic [1:0]  lane_i,
   input  logic [7:0]  data_i,
   output logic        full_o,
   output logic [29:0] addr_o,
   output logic [1:0]  lane_o,
   output logic [7:0]  data_o
);

   logic        valid_q;
   logic [29:0] addr_q;
   logic [1:0]  lane_q;
   logic [7:0]  data_q;

   // A push in the same cycle as the pop refills the entry.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         lane_q  <= '0;
         data_q  <= '0;
      end else if (push_i) begin
         valid_q <= 1'b1;
         addr_q  <= addr_i;
         lane_q  <= lane_i;
         data_q  <= data_i;
      end else if (pop_i) begin
         valid_q <= 1'b0;
      end
   end

   assign full_o = valid_q;
   assign addr_o = addr_q;
   assign lane_o = lane_q;
   assign data_o = data_q;

endmodule

// File: rtl/mem_bridge.sv
// CPU byte bus to 32-bit word memory bridge with a one-word read line buffer.
// Define MEM_BRIDGE_WBUF_EN to add a one-entry posted write buffer.
module mem_bridge
   import mem_bridge_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] address,
   input  logic [7:0]  cpu_out,
   input  logic        cpu_we,
   output logic [7:0]  cpu_in,
   output logic        ce,
   output logic [29:0] mem_addr,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   state_e      state_q, state_d;
   logic        lv_q;
   logic [29:0] ltag_q;
   logic [31:0] ldata_q, ldata_d;
   logic        req_q, we_q;
   logic [3:0]  be_q;
   logic [29:0] addr_q;
   logic [31:0] wdata_q;

   logic        hit, ce_c, start_rd, start_wr, load_line, wt_en;
   logic [29:0] wr_tag;
   logic [1:0]  wr_lane;
   logic [7:0]  wr_byte;

`ifdef MEM_BRIDGE_WBUF_EN
   logic        wb_full, wb_push, wb_pop;
   logic [29:0] wb_addr;
   logic [1:0]  wb_lane;
   logic [7:0]  wb_data;

   mem_bridge_wbuf u_wbuf (
      .clk_i  (clock),
      .rst_ni (reset_n),
      .push_i (wb_push),
      .pop_i  (wb_pop),
      .addr_i (address[31:2]),
      .lane_i (address[1:0]),
      .data_i (cpu_out),
      .full_o (wb_full),
      .addr_o (wb_addr),
      .lane_o (wb_lane),
      .data_o (wb_data)
   );
`endif

   assign hit       = lv_q && (ltag_q == address[31:2]);
   assign cpu_in    = byte_sel(ldata_q, address[1:0]);
   assign ce        = ce_c & reset_n;
   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_be    = be_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   always_comb begin
      state_d   = state_q;
      ce_c      = 1'b0;
      start_rd  = 1'b0;
      start_wr  = 1'b0;
      load_line = 1'b0;
      wt_en     = 1'b0;
      wr_tag    = address[31:2];
      wr_lane   = address[1:0];
      wr_byte   = cpu_out;
`ifdef MEM_BRIDGE_WBUF_EN
      wb_push   = 1'b0;
      wb_pop    = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
`ifdef MEM_BRIDGE_WBUF_EN
            if (wb_full) begin
               // Drain before anything else reaches memory; read hits still complete.
               ce_c     = !cpu_we && hit;
               start_wr = 1'b1;
               wr_tag   = wb_addr;
               wr_lane  = wb_lane;
               wr_byte  = wb_data;
               state_d  = StWr;
            end else if (cpu_we) begin
               ce_c    = 1'b1;
               wb_push = 1'b1;
               wt_en   = 1'b1;
            end else if (hit) begin
               ce_c = 1'b1;
            end else begin
               start_rd = 1'b1;
               state_d  = StRd;
            end
`else
            if (cpu_we) begin
               start_wr = 1'b1;
               state_d  = StWr;
            end else if (hit) begin
               ce_c = 1'b1;
            end else begin
               start_rd = 1'b1;
               state_d  = StRd;
            end
`endif
         end
         StRd: begin
            if (mem_ack) begin
               load_line = 1'b1;
               state_d   = StIdle;
            end
         end
         StWr: begin
`ifdef MEM_BRIDGE_WBUF_EN
            if (mem_ack) begin
               wb_pop  = 1'b1;
               state_d = StIdle;
               if (cpu_we) begin
                  ce_c    = 1'b1;
                  wb_push = 1'b1;
                  wt_en   = 1'b1;
               end else begin
                  ce_c = hit;
               end
            end else begin
               ce_c = !cpu_we && hit;
            end
`else
            if (mem_ack) state_d = StWdone;
`endif
         end
         StWdone: begin
`ifndef MEM_BRIDGE_WBUF_EN
            ce_c  = 1'b1;
            wt_en = 1'b1;
`endif
            state_d = StIdle;
         end
      endcase
   end

   // Write-through: the CPU still presents the completing write's address and byte.
   always_comb begin
      ldata_d = ldata_q;
      if (load_line) begin
         ldata_d = mem_rdata;
      end else if (wt_en && hit) begin
         ldata_d[{address[1:0], 3'b000} +: 8] = cpu_out;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         lv_q    <= 1'b0;
         ltag_q  <= '0;
         ldata_q <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         be_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         ldata_q <= ldata_d;
         if (load_line) begin
            lv_q   <= 1'b1;
            ltag_q <= addr_q;
         end
         if (start_rd) begin
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            be_q   <= 4'hF;
            addr_q <= address[31:2];
         end else if (start_wr) begin
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            be_q    <= lane_be(wr_lane);
            addr_q  <= wr_tag;
            wdata_q <= {4{wr_byte}};
         end else if (mem_ack) begin
            req_q <= 1'b0;
         end
      end
   end

endmodule

// File: doc/mem_bridge.md
# mem_bridge

Memory-side responder for the CPU byte bus. Serves the CPU's per-cycle byte reads and byte writes from a 32-bit word memory with a req/ack handshake, and stalls the CPU through `ce` whenever an access cannot finish in the current cycle. It holds a one-word read line buffer so that sequential fetches within a word cost one cycle. Optionally, it holds a one-entry posted write buffer. It sits between the `cpu` address/in/out/we pins and the system memory or SDRAM controller port.

## Interface
- No parameters. Address width is fixed at 32; memory word address is `address[31:2]`.
- `clock` in 1: single system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 32: CPU byte address, valid every cycle.
- `cpu_out` in 8: CPU write byte.
- `cpu_we` in 1: CPU write strobe. A cycle with `cpu_we`=1 is a write; every other cycle is a read.
- `cpu_in` out 8: read byte returned to the CPU.
- `ce` out 1: CPU clock enable. 1 means the current access completes this edge; 0 means the CPU holds address, `cpu_we` and `cpu_out`.
- `mem_addr` out 30: word address.
- `mem_req` out 1: request; held until ack.
- `mem_we` out 1: 1 = write request.
- `mem_be` out 4: byte enables; all ones for reads.
- `mem_wdata` out 32: write data, byte replicated on all lanes.
- `mem_rdata` in 32: read word, valid when `mem_ack`=1.
- `mem_ack` in 1: one-cycle acknowledge; ignored while `mem_req`=0.

## Operation
- **Line buffer**
  - Contents: `lv` (valid bit), `ltag` (30 bits), `ldata` (32 bits).
  - Hit condition: `lv` and `ltag == address[31:2]`.
  - `cpu_in = ldata` byte selected by `address[1:0]` (0 = bits 7:0), combinational at all times.
- **FSM states:** IDLE, RD, WR, WDONE.
- **IDLE**
  - Read hit: `ce`=1, no memory activity.
  - Read miss: `ce`=0, go to RD.
  - Write, without the write buffer: `ce`=0, go to WR with the address and byte latched.
- **RD**
  - `mem_req`=1, `mem_we`=0, `mem_be`=4'hF, `mem_addr=address[31:2]`.
  - On `mem_ack`: load `ldata=mem_rdata`, `ltag`, set `lv`=1, go to IDLE.
  - `ce`=0 throughout. The next IDLE cycle is a hit.
- **WR**
  - `mem_req`=1, `mem_we`=1, `mem_be` = one-hot of the latched `addr[1:0]`, `mem_wdata={4{byte}}`.
  - On `mem_ack`: go to WDONE (direct mode) or IDLE (buffered drain).
  - `ce`=0 unless a buffered-mode rule below applies.
- **WDONE:** `ce`=1 for exactly one cycle, completing the CPU write. Always go to IDLE.
- **Write-through coherency:** any write whose word matches a valid line updates the addressed `ldata` byte. The update happens on the cycle the write completes (`ce`=1) toward the CPU.
- **Request stability:** `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` stay stable while `mem_req`=1.
- **Reset:** an asynchronous reset mid-transaction drops `mem_req` immediately. The memory side tolerates an abandoned request.

## Timing
- **Reset values:** state IDLE, `lv`=0, `ltag`=0, `ldata`=0, `cpu_in`=8'h00, `ce`=0, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0, write buffer empty.
- **Read hit:** 1 cycle (`ce`=1 on the presenting cycle).
- **Read miss** (ack on the Nth RD cycle): N+2 cycles. With ack on the first RD cycle, `ce` rises on the 3rd cycle.
- **Direct write** (ack on the Nth WR cycle): N+2 cycles; `ce`=1 in WDONE only.
- **Word boundary:** address 0x...03 → 0x...04 misses. Address 0xFFFFFFFF → 0x00000000 wraps the tag naturally.
- **Simultaneous events:** `mem_ack` in the cycle the FSM leaves RD/WR is consumed once. No spurious second request is issued.

## Configuration
- `MEM_BRIDGE_WBUF_EN` defined: one-entry posted write buffer.
  - A write with the buffer empty is captured in IDLE with `ce`=1 (1 cycle).
  - The FSM drains the buffer through WR back to IDLE.
  - A write while the buffer is full gives `ce`=0 until the drain ack, then the write is captured.
  - Read hits proceed during a drain.
  - A read miss waits for the drain to finish before entering RD, so ordering is preserved.
- Undefined: no buffer; every write goes IDLE→WR→WDONE.

## Structure
- `mem_bridge_pkg`: state enum (IDLE, RD, WR, WDONE), `lane_be(addr[1:0])` one-hot function, `byte_sel(word, addr[1:0])` function.
- Sub-module `mem_bridge_wbuf` (present only under the macro): holds addr/byte/valid; push, pop and full.

## Test plan
- **Reset then miss:** fetch at 0x100, `mem_rdata`=0x44332211, ack after 2 cycles → `ce`=1 on cycle 4; reads at 0x100..0x103 return 11, 22, 33, 44 with `ce`=1 each cycle.
- **Write-through:** write 0xAA to 0x102 while the line is 0x100 → `mem_be`=4'b0100, `mem_wdata`=0xAAAAAAAA; a subsequent read of 0x102 hits with 0xAA and no request.
- **Direct write:** ack on the 1st WR cycle → `ce` is low for 2 cycles then high 1 cycle; exactly one `mem_req` write.
- **Buffered mode:** two back-to-back writes → first `ce`=1 immediately, second stalls until the drain ack. A read miss issued during the drain starts RD only after the write ack.
- **Reset mid-RD:** assert `reset_n`=0 while `mem_req`=1 → `mem_req` and `ce` drop asynchronously; after release, the same address misses again.
- **Boundary:** read 0x1FF then 0x200 → the second read misses with `mem_addr`=0x80.
